uart_tx_fifo_param: RTL and testbench
=====================================

# uart_tx_fifo_param

Parametrised, buffered UART transmitter; successor to the fixed 8N1 `uartTransmiter`. Accepts bytes through a valid/ready handshake into an internal FIFO and serialises them back-to-back. Data width, stop-bit count, parity and FIFO depth are configurable. Sits between the host-side byte producer and the TX pin, alongside `uartReceiber`.

## Interface
- `CLKS_PER_BIT`, 5208: clock cycles per serial bit; legal range ≥ 2.
- `DATA_BITS`, 8: data bits per frame; legal range 5..9.
- `STOP_BITS`, 1: stop bits per frame; legal values 1 or 2.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd; ignored when parity is compiled out.
- `FIFO_DEPTH`, 4: TX buffer entries; power of two, ≥ 2.

- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `dataValid` in 1: a byte is offered on `P_BYTE`.
- `P_BYTE` in DATA_BITS: data word, sent LSB first.
- `ready` out 1: FIFO not full; a word is accepted when `dataValid && ready` at a rising edge.
- `active` out 1: high whenever the FSM is not IDLE.
- `serialStream` out 1: TX line, idle-high.
- `done` out 1: one-cycle pulse per completed frame.

## Operation
- Reset values: `serialStream`=1, `active`=0, `done`=0, `ready`=1; FIFO is emptied; FSM goes to IDLE; baud and bit counters are 0.
- `ready` = !full, driven combinationally from the FIFO count. Writes while full are ignored.
- FSM states:
  - IDLE: line is 1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: line is 0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: shift out `DATA_BITS` bits, LSB first, each held CLKS_PER_BIT cycles. Then go to PARITY if parity is enabled, else STOP.
  - PARITY: line = XOR of the data bits, XOR PARITY_ODD, held CLKS_PER_BIT cycles; then STOP.
  - STOP: line is 1 for STOP_BITS×CLKS_PER_BIT cycles.
- End of the last STOP cycle:
  - `done` pulses in the next cycle.
  - If the FIFO is non-empty, pop and enter START directly, with no idle gap.
  - Otherwise go to IDLE.
- Baud counter runs 0..CLKS_PER_BIT-1 and wraps. Its width is $clog2(CLKS_PER_BIT). The bit index has width $clog2(DATA_BITS+1).
- Simultaneous push and pop: both take effect and the count is unchanged. A push while full and popping in the same cycle is still rejected, because `ready` reflects full.
- Reset mid-frame aborts the frame. `serialStream` returns to 1 on the next edge, queued data is discarded, and no `done` pulse is produced.

## Timing
- Push accepted at edge N → FIFO non-empty at N+1 → FSM pops at edge N+1 → `serialStream`=0 and `active`=1 from N+2.
- Frame length F = CLKS_PER_BIT × (1 + DATA_BITS + P + STOP_BITS), where P = 1 if parity is compiled in, else 0.
- `done` is high for exactly one cycle, F cycles after the start bit begins. In back-to-back operation it coincides with the first cycle of the next START.
- `active` drops in the same cycle `done` pulses when the FIFO is empty.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state and parity logic are built; P=1.
- `UART_TX_PARITY_EN` undefined: no PARITY state, PARITY_ODD is unused, DATA goes straight to STOP; P=0.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - a parity function;
  - the line level constants (IDLE_LEVEL=1, START_LEVEL=0).
- One sub-module, `uart_tx_fifo`: synchronous FIFO parametrised by width and depth. It has push/pop ports and full/empty flags, uses pointers one bit wider than the address, and implements the same-cycle push/pop rule above.

## Test plan
- CLKS_PER_BIT=4, 8N1, parity out, push 0xAB → `serialStream` per 4-cycle bit: 0,1,1,0,1,0,1,0,1,1. `done` pulses once, 40 cycles after the start bit begins.
- Parity in, PARITY_ODD=0, push 0xAB (five ones) → parity bit 1. With PARITY_ODD=1 → parity bit 0. Frame is 44 cycles.
- DATA_BITS=7, STOP_BITS=2, parity in, PARITY_ODD=1, push 7'h55 → 0, then 1,0,1,0,1,0,1, then 1 (parity), then 1,1 (stop bits).
- FIFO_DEPTH=4, push 0x01..0x06 on consecutive cycles:
  - words 1–5 are accepted and the 6th is held off with `ready`=0 until the first pop after frame 1;
  - all six frames are sent with no idle gap;
  - six `done` pulses are produced.
- Assert `rst` during the DATA phase of the first of three queued bytes → next cycle `serialStream`=1, `active`=0, `ready`=1. No further frames and no `done` pulse.
- Push 0x3F and loop `serialStream` into `uartReceiber` (8N1 build) → received byte 0x3F.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, line levels and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic IDLE_LEVEL    = 1'b1;
    localparam logic START_LEVEL   = 1'b0;
    localparam int   MAX_DATA_BITS = 9;

    // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO for the UART transmitter.
// Read data is valid whenever the FIFO is not empty.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    // The extra pointer bit separates the full and empty cases when the addresses match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Buffered, parametrised UART transmitter (FIFO in front of a frame serialiser).
// Define UART_TX_PARITY_EN to build the parity bit; otherwise frames go DATA -> STOP.
module uart_tx_fifo_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dataValid,
    input  logic [DATA_BITS-1:0] P_BYTE,
    output logic                 ready,
    output logic                 active,
    output logic                 serialStream,
    output logic                 done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("CLKS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data
        $error("DATA_BITS must be within 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
        $error("PARITY_ODD must be 0 or 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end

    tx_state_e            state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] sr_q, sr_d;
    logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 baud_end;
    logic                 line;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (dataValid),
        .wdata_i (P_BYTE),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign baud_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        sr_d     = sr_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif

        if (state_q != IDLE) begin
            baud_d = baud_end ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (baud_end) begin
                    sr_d = sr_q >> 1;
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (baud_end) begin
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        done_d = 1'b1;
                        bit_d  = '0;
                        // Chain straight into the next start bit when more data is queued.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            state_d  = START;
                        end else begin
                            state_d  = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (fifo_pop) begin
            sr_d   = fifo_rdata;
            baud_d = '0;
            bit_d  = '0;
`ifdef UART_TX_PARITY_EN
            par_d  = parity_of(MAX_DATA_BITS'(fifo_rdata), 1'(PARITY_ODD));
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        line = IDLE_LEVEL;
        case (state_q)
            START:  line = START_LEVEL;
            DATA:   line = sr_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY: line = par_q;
`endif
            default: line = IDLE_LEVEL;
        endcase
    end

    assign serialStream = line;
    assign active       = (state_q != IDLE);
    assign done         = done_q;
    assign ready        = !fifo_full;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Directed bench for uart_tx_fifo_param: an 8-bit/1-stop and a 7-bit/2-stop/odd instance.
module tb_uart_tx_fifo_param;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB_A = 1 + 8 + P + 1;
    localparam int NB_B = 1 + 7 + P + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       valid_a = 1'b0;
    logic [7:0] byte_a  = '0;
    logic       ready_a, active_a, ser_a, done_a;
    logic       valid_b = 1'b0;
    logic [6:0] byte_b  = '0;
    logic       ready_b, active_b, ser_b, done_b;

    uart_tx_fifo_param #(
        .CLKS_PER_BIT (CPB), .DATA_BITS (8), .STOP_BITS (1), .PARITY_ODD (0), .FIFO_DEPTH (4)
    ) dut_a (
        .clk (clk), .rst (rst), .dataValid (valid_a), .P_BYTE (byte_a),
        .ready (ready_a), .active (active_a), .serialStream (ser_a), .done (done_a)
    );

    uart_tx_fifo_param #(
        .CLKS_PER_BIT (CPB), .DATA_BITS (7), .STOP_BITS (2), .PARITY_ODD (1), .FIFO_DEPTH (2)
    ) dut_b (
        .clk (clk), .rst (rst), .dataValid (valid_b), .P_BYTE (byte_b),
        .ready (ready_b), .active (active_b), .serialStream (ser_b), .done (done_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt_a = 0;

    always @(posedge clk) if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line levels, LSB first: start, data, [parity], stop(s).
    function automatic logic [15:0] frame_a(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {5'b0, 1'b1, ^d, d, 1'b0};
`else
        return {6'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    // Samples one whole frame, one negedge per clock, starting with the first start-bit cycle.
    task automatic frame_check(input int which, input logic [15:0] exp, input int nb,
                               input logic done_first, input string tag);
        for (int k = 0; k < nb * CPB; k++) begin
            @(negedge clk);
            check($sformatf("%s_line%0d", tag, k), (which != 0) ? ser_b : ser_a, exp[k / CPB]);
            check($sformatf("%s_done%0d", tag, k), (which != 0) ? done_b : done_a,
                  (k == 0) ? done_first : 1'b0);
            check($sformatf("%s_act%0d", tag, k), (which != 0) ? active_b : active_a, 1'b1);
        end
    endtask

    task automatic frame_end(input int which, input string tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, (which != 0) ? done_b : done_a, 1'b1);
        check({tag, "_act_drop"}, (which != 0) ? active_b : active_a, 1'b0);
        check({tag, "_line_idle"}, (which != 0) ? ser_b : ser_a, 1'b1);
        @(negedge clk);
        check({tag, "_done_clear"}, (which != 0) ? done_b : done_a, 1'b0);
    endtask

    initial begin
        int   wait_n;
        int   done_base;
        logic any_low, any_done, any_act, found;
        logic [7:0] rx;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ser_a", ser_a, 1'b1);
        check("rst_act_a", active_a, 1'b0);
        check("rst_done_a", done_a, 1'b0);
        check("rst_ready_a", ready_a, 1'b1);
        check("rst_ser_b", ser_b, 1'b1);
        check("rst_ready_b", ready_b, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // 0xAB, LSB first: 0 | 1 1 0 1 0 1 0 1 | (even parity 1) | 1
        valid_a = 1'b1;
        byte_a  = 8'hAB;
        check("t1_ready", ready_a, 1'b1);
        @(negedge clk);
        valid_a = 1'b0;
        check("t1_lat_line", ser_a, 1'b1);
        check("t1_lat_act", active_a, 1'b0);
`ifdef UART_TX_PARITY_EN
        frame_check(0, 16'b00000_1_1_10101011_0, NB_A, 1'b0, "t1");
`else
        frame_check(0, 16'b000000_1_10101011_0, NB_A, 1'b0, "t1");
`endif
        frame_end(0, "t1");

        // 7'h55, LSB first: 0 | 1 0 1 0 1 0 1 | (odd parity 1) | 1 1
        valid_b = 1'b1;
        byte_b  = 7'h55;
        @(negedge clk);
        valid_b = 1'b0;
        check("t2_lat_line", ser_b, 1'b1);
`ifdef UART_TX_PARITY_EN
        frame_check(1, 16'b00000_11_1_1010101_0, NB_B, 1'b0, "t2");
`else
        frame_check(1, 16'b000000_11_1010101_0, NB_B, 1'b0, "t2");
`endif
        frame_end(1, "t2");

        // Six pushes on consecutive cycles into a four-deep FIFO.
        done_base = done_cnt_a;
        fork
            begin
                for (int w = 1; w <= 6; w++) begin
                    valid_a = 1'b1;
                    byte_a  = 8'(w);
                    check($sformatf("t3_ready_w%0d", w), ready_a, (w <= 5) ? 1'b1 : 1'b0);
                    @(negedge clk);
                end
                // First pop after frame 1 lands at the frame's last edge: F-3 negedges after word 6 was offered.
                wait_n = 1;
                while (!ready_a && wait_n < 200) begin
                    @(negedge clk);
                    wait_n++;
                end
                check("t3_ready_wait", wait_n, NB_A * CPB - 3);
                @(negedge clk);
                valid_a = 1'b0;
            end
            begin
                @(posedge clk);
                @(posedge clk);
                for (int i = 1; i <= 6; i++)
                    frame_check(0, frame_a(8'(i)), NB_A, (i > 1) ? 1'b1 : 1'b0, $sformatf("t3_f%0d", i));
                frame_end(0, "t3");
            end
        join
        check("t3_done_count", done_cnt_a - done_base, 6);

        // Reset during the DATA phase of the first of three queued bytes.
        done_base = done_cnt_a;
        valid_a = 1'b1;
        byte_a  = 8'h11;
        @(negedge clk);
        byte_a  = 8'h22;
        @(negedge clk);
        byte_a  = 8'h33;
        @(negedge clk);
        valid_a = 1'b0;
        repeat (6) @(negedge clk);
        check("t4_in_frame", active_a, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_ser", ser_a, 1'b1);
        check("t4_act", active_a, 1'b0);
        check("t4_ready", ready_a, 1'b1);
        check("t4_done", done_a, 1'b0);
        any_low = 1'b0;
        any_done = 1'b0;
        any_act = 1'b0;
        repeat (60) begin
            @(negedge clk);
            any_low  = any_low | ~ser_a;
            any_done = any_done | done_a;
            any_act  = any_act | active_a;
        end
        check("t4_no_frame", any_low, 1'b0);
        check("t4_no_done", any_done, 1'b0);
        check("t4_no_active", any_act, 1'b0);
        check("t4_done_count", done_cnt_a - done_base, 0);

        // Loopback: decode the line as an 8N1 receiver sampling mid-bit.
        valid_a = 1'b1;
        byte_a  = 8'h3F;
        @(negedge clk);
        valid_a = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (ser_a == 1'b0) found = 1'b1;
        end
        check("t5_start_seen", found, 1'b1);
        rx = '0;
        if (found) begin
            repeat (2) @(negedge clk);
            check("t5_start_mid", ser_a, 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                rx[i] = ser_a;
            end
            repeat (CPB * (1 + P)) @(negedge clk);
            check("t5_stop", ser_a, 1'b1);
        end
        check("t5_rx_byte", rx, 8'h3F);
        repeat (10) @(negedge clk);
        check("t5_idle", active_a, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
